// File: rtl/led_pattern_sequencer.sv
// Command-driven LED ring sequencer: prescaled step timing, four patterns, run/pause/step control.
// Registered led/led_center one cycle after a step or command; cmd_ready drops only in the single STEP cycle.
module led_pattern_sequencer #(
  parameter int BASE_DIV = 12000000 / 16,
  parameter int DIV_W    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_arg,
  output logic [3:0] led,
  output logic       led_center,
  output logic       tick,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_MODE  = 3'd3;
  localparam logic [2:0] OP_SPEED = 3'd4;
  localparam logic [2:0] OP_DIR   = 3'd5;
  localparam logic [2:0] OP_STEP  = 3'd6;
  localparam logic [2:0] OP_HOME  = 3'd7;

  localparam logic [1:0] M_ROTATE = 2'd0;
  localparam logic [1:0] M_BOUNCE = 2'd1;
  localparam logic [1:0] M_BLINK  = 2'd2;

  localparam logic [DIV_W-1:0] PRE_TC = DIV_W'(BASE_DIV - 1);

  state_t           state_q, state_n;
  logic [1:0]       pos_q, pos_n, mode_q, mode_n;
  logic [3:0]       speed_q, speed_n, scnt_q, scnt_n, led_q, led_n;
  logic [2:0]       phase_q, phase_n;
  logic [DIV_W-1:0] pre_q, pre_n;
  logic             dir_q, dir_n, bdir_q, bdir_n, ctr_q, ctr_n;
  logic             counting, base, fire, accept;

  function automatic logic [3:0] pattern(input logic [1:0] m, input logic [1:0] p,
                                         input logic [2:0] ph, input logic d);
    logic [3:0] f;
    f = 4'b0000;
    case (m)
      M_ROTATE, M_BOUNCE: f = 4'b0001 << p;
      M_BLINK:            f = {4{ph[0]}};
      default: begin
        case (ph)
          3'd0:    f = 4'b0001;
          3'd1:    f = 4'b0011;
          3'd2:    f = 4'b0111;
          3'd3:    f = 4'b1111;
          default: f = 4'b0000;
        endcase
        if (d) f = {f[0], f[1], f[2], f[3]};
      end
    endcase
    return f;
  endfunction

  assign counting   = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign base       = counting && (pre_q == PRE_TC);
  assign fire       = ((state_q == S_RUN) && base && (scnt_q == speed_q)) || (state_q == S_STEP);
  assign cmd_ready  = (state_q != S_STEP);
  assign accept     = cmd_valid && cmd_ready;
  assign tick       = fire;
  assign led        = led_q;
  assign led_center = ctr_q;
  assign state      = state_q;

  always_comb begin
    state_n = state_q;
    pos_n   = pos_q;
    mode_n  = mode_q;
    speed_n = speed_q;
    dir_n   = dir_q;
    bdir_n  = bdir_q;
    phase_n = phase_q;
    pre_n   = pre_q;
    scnt_n  = scnt_q;
    ctr_n   = ctr_q;

    if (counting) pre_n = base ? '0 : pre_q + DIV_W'(1);
    if (state_q == S_RUN && base) scnt_n = fire ? 4'd0 : scnt_q + 4'd1;
    if (state_q == S_PAUSE && base) ctr_n = ~ctr_q;

    // The step advances with the pre-command configuration; commands below override.
    if (fire) begin
      case (mode_q)
        M_ROTATE: pos_n = dir_q ? pos_q - 2'd1 : pos_q + 2'd1;
        M_BOUNCE: begin
          if (!bdir_q && pos_q == 2'd3) begin
            bdir_n = 1'b1;
            pos_n  = 2'd2;
          end else if (bdir_q && pos_q == 2'd0) begin
            bdir_n = 1'b0;
            pos_n  = 2'd1;
          end else begin
            pos_n = bdir_q ? pos_q - 2'd1 : pos_q + 2'd1;
          end
        end
        M_BLINK:  phase_n = {2'b00, ~phase_q[0]};
        default:  phase_n = (phase_q >= 3'd4) ? 3'd0 : phase_q + 3'd1;
      endcase
    end

    if (state_q == S_STEP) state_n = S_PAUSE;

    if (accept) begin
      case (cmd_op)
        OP_START: begin
          if (state_q == S_IDLE) begin
            state_n = S_RUN;
            pre_n   = '0;
            scnt_n  = 4'd0;
          end else if (state_q == S_PAUSE) begin
            state_n = S_RUN;
            pre_n   = '0;
          end
        end
        OP_STOP: begin
          if (state_q == S_RUN) begin
            state_n = S_PAUSE;
          end else if (state_q == S_PAUSE) begin
            state_n = S_IDLE;
            pos_n   = 2'd0;
            phase_n = 3'd0;
          end
        end
        OP_MODE: begin
          mode_n  = cmd_arg[1:0];
          pos_n   = 2'd0;
          phase_n = 3'd0;
          bdir_n  = dir_q;
        end
        OP_SPEED: begin
          speed_n = cmd_arg;
          pre_n   = '0;
          scnt_n  = 4'd0;
        end
        OP_DIR:  dir_n = cmd_arg[0];
        OP_STEP: if (state_q == S_IDLE || state_q == S_PAUSE) state_n = S_STEP;
        OP_HOME: begin
          pos_n   = 2'd0;
          phase_n = 3'd0;
          bdir_n  = dir_q;
        end
        default: ;
      endcase
    end

    if (state_n == S_RUN) ctr_n = 1'b1;
    else if (state_n == S_IDLE) ctr_n = 1'b0;

    led_n = (state_n == S_IDLE) ? 4'b0000 : pattern(mode_n, pos_n, phase_n, dir_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_q   <= 2'd0;
      mode_q  <= M_ROTATE;
      speed_q <= 4'd0;
      dir_q   <= 1'b0;
      bdir_q  <= 1'b0;
      phase_q <= 3'd0;
      pre_q   <= '0;
      scnt_q  <= 4'd0;
      led_q   <= 4'b0000;
      ctr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      pos_q   <= pos_n;
      mode_q  <= mode_n;
      speed_q <= speed_n;
      dir_q   <= dir_n;
      bdir_q  <= bdir_n;
      phase_q <= phase_n;
      pre_q   <= pre_n;
      scnt_q  <= scnt_n;
      led_q   <= led_n;
      ctr_q   <= ctr_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed plus randomized bench for led_pattern_sequencer against a cycle reference model.
module tb_led_pattern_sequencer;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_arg = 4'd0;
  logic [3:0] led;
  logic       led_center;
  logic       tick;
  logic [1:0] state;

  int tests = 0;
  int failed = 0;

  led_pattern_sequencer #(.BASE_DIV(BD), .DIV_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .led(led), .led_center(led_center),
    .tick(tick), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: states 0 IDLE, 1 RUN, 2 PAUSE, 3 STEP
  int m_st, m_pos, m_mode, m_speed, m_dir, m_bdir, m_phase, m_pre, m_scnt, m_led, m_ctr;
  int fill_tab[5] = '{1, 3, 7, 15, 0};
  logic obs_tick, obs_rdy;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pos = 0; m_mode = 0; m_speed = 0; m_dir = 0; m_bdir = 0;
    m_phase = 0; m_pre = 0; m_scnt = 0; m_led = 0; m_ctr = 0;
  endtask

  function automatic int m_fire();
    return ((m_st == 1 && m_pre == BD - 1 && m_scnt == m_speed) || m_st == 3) ? 1 : 0;
  endfunction

  function automatic int m_pattern();
    int f, r;
    if (m_mode <= 1) return 1 << m_pos;
    if (m_mode == 2) return (m_phase % 2 == 1) ? 15 : 0;
    f = fill_tab[m_phase];
    if (m_dir == 0) return f;
    r = 0;
    for (int b = 0; b < 4; b++) if (((f >> b) & 1) == 1) r = r | (8 >> b);
    return r;
  endfunction

  task automatic model_edge(input logic v, input logic [2:0] op, input logic [3:0] arg);
    int nst, base, fire, acc;
    base = ((m_st == 1 || m_st == 2) && m_pre == BD - 1) ? 1 : 0;
    fire = m_fire();
    acc  = (v && m_st != 3) ? 1 : 0;
    nst  = m_st;
    if (m_st == 1 || m_st == 2) m_pre = (m_pre + 1) % BD;
    if (m_st == 1 && base == 1) m_scnt = (fire == 1) ? 0 : m_scnt + 1;
    if (m_st == 2 && base == 1) m_ctr = 1 - m_ctr;
    if (fire == 1) begin
      case (m_mode)
        0: m_pos = (m_pos + ((m_dir == 1) ? 3 : 1)) % 4;
        1: begin
          if ((m_pos == 3 && m_bdir == 0) || (m_pos == 0 && m_bdir == 1)) m_bdir = 1 - m_bdir;
          m_pos = (m_pos + ((m_bdir == 1) ? 3 : 1)) % 4;
        end
        2: m_phase = (m_phase + 1) % 2;
        default: m_phase = (m_phase + 1) % 5;
      endcase
    end
    if (m_st == 3) nst = 2;
    if (acc == 1) begin
      case (op)
        1: if (m_st == 0) begin nst = 1; m_pre = 0; m_scnt = 0; end
           else if (m_st == 2) begin nst = 1; m_pre = 0; end
        2: if (m_st == 1) nst = 2;
           else if (m_st == 2) begin nst = 0; m_pos = 0; m_phase = 0; end
        3: begin m_mode = int'(arg) % 4; m_pos = 0; m_phase = 0; m_bdir = m_dir; end
        4: begin m_speed = int'(arg); m_pre = 0; m_scnt = 0; end
        5: m_dir = int'(arg) % 2;
        6: if (m_st == 0 || m_st == 2) nst = 3;
        7: begin m_pos = 0; m_phase = 0; m_bdir = m_dir; end
        default: ;
      endcase
    end
    m_st = nst;
    if (nst == 1) m_ctr = 1;
    else if (nst == 0) m_ctr = 0;
    m_led = (nst == 0) ? 0 : m_pattern();
  endtask

  // One clock cycle: drive after negedge, compare, then advance model at posedge.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [3:0] arg);
    cmd_valid = v; cmd_op = op; cmd_arg = arg;
    #1;
    obs_tick = tick;
    obs_rdy  = cmd_ready;
    chk("tick",  8'(tick),       8'(m_fire()));
    chk("ready", 8'(cmd_ready),  8'((m_st != 3) ? 1 : 0));
    chk("led",   8'(led),        8'(m_led));
    chk("ctr",   8'(led_center), 8'(m_ctr));
    chk("state", 8'(state),      8'(m_st));
    @(posedge clk);
    model_edge(v, op, arg);
    @(negedge clk);
  endtask

  task automatic run_until_tick(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      cyc(1'b0, 3'd0, 4'd0);
      if (obs_tick) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, ticks;
    int seq_rot[4]  = '{2, 4, 8, 1};
    int seq_bnc[7]  = '{2, 4, 8, 4, 2, 1, 2};
    int seq_fill[5] = '{3, 7, 15, 0, 1};
    logic [3:0] held, prev;
    logic [3:0] ra;
    logic [2:0] ro;

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_led", 8'(led), 8'd0);
    chk("rst_ctr", 8'(led_center), 8'd0);
    chk("rst_tick", 8'(tick), 8'd0);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_ready", 8'(cmd_ready), 8'd1);
    rst_n = 1'b1;

    // START, rotate up at speed 0
    cyc(1'b1, 3'd1, 4'd0);
    chk("start_led", 8'(led), 8'd1);
    for (int k = 0; k < 4; k++) begin
      run_until_tick(20, n);
      chk("rot_period", 8'(n), 8'd4);
      chk("rot_led", 8'(led), 8'(seq_rot[k]));
    end
    chk("run_ctr", 8'(led_center), 8'd1);

    // Asynchronous reset mid-period
    cyc(1'b0, 3'd0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", 8'(led), 8'd0);
    chk("arst_ctr", 8'(led_center), 8'd0);
    chk("arst_tick", 8'(tick), 8'd0);
    chk("arst_state", 8'(state), 8'd0);
    chk("arst_ready", 8'(cmd_ready), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(1'b0, 3'd0, 4'd0);

    // SET_SPEED 2 while running, then reverse direction
    cyc(1'b1, 3'd1, 4'd0);
    cyc(1'b0, 3'd0, 4'd0);
    cyc(1'b1, 3'd4, 4'd2);
    run_until_tick(40, n);
    chk("spd_first", 8'(n), 8'd12);
    run_until_tick(40, n);
    chk("spd_period", 8'(n), 8'd12);
    prev = led;
    cyc(1'b1, 3'd5, 4'd1);
    run_until_tick(40, n);
    chk("dir_rev", 8'(led), 8'({prev[0], prev[3:1]}));

    // BOUNCE and FILL
    cyc(1'b1, 3'd4, 4'd0);
    cyc(1'b1, 3'd5, 4'd0);
    cyc(1'b1, 3'd3, 4'd1);
    chk("bnc_start", 8'(led), 8'd1);
    for (int k = 0; k < 7; k++) begin
      run_until_tick(20, n);
      chk("bnc_led", 8'(led), 8'(seq_bnc[k]));
    end
    cyc(1'b1, 3'd3, 4'd3);
    chk("fill_start", 8'(led), 8'd1);
    for (int k = 0; k < 5; k++) begin
      run_until_tick(20, n);
      chk("fill_led", 8'(led), 8'(seq_fill[k]));
    end

    // Pause, step, stop to idle
    cyc(1'b1, 3'd3, 4'd0);
    cyc(1'b1, 3'd2, 4'd0);
    held = led;
    repeat (9) cyc(1'b0, 3'd0, 4'd0);
    chk("pause_led", 8'(led), 8'(held));
    chk("pause_state", 8'(state), 8'd2);
    ticks = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 3'd6, 4'd0);
      chk("step_ready", 8'(obs_rdy), 8'((k % 2 == 0) ? 1 : 0));
      if (obs_tick) ticks++;
    end
    chk("step_ticks", 8'(ticks), 8'd2);
    cyc(1'b0, 3'd0, 4'd0);
    cyc(1'b1, 3'd2, 4'd0);
    chk("stop_idle", 8'(state), 8'd0);
    chk("stop_led", 8'(led), 8'd0);

    // STOP coinciding with a step, then restart
    cyc(1'b1, 3'd1, 4'd0);
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      if (tick) begin
        prev = led;
        cyc(1'b1, 3'd2, 4'd0);
        n = 1;
      end else begin
        cyc(1'b0, 3'd0, 4'd0);
      end
    end
    chk("stop_tick_seen", 8'(n), 8'd1);
    chk("stop_tick_state", 8'(state), 8'd2);
    chk("stop_tick_led", 8'(led), 8'({prev[2:0], prev[3]}));
    cyc(1'b1, 3'd1, 4'd0);
    run_until_tick(20, n);
    chk("restart_lat", 8'(n), 8'd4);

    // Randomized command stream
    for (int i = 0; i < 2500; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 4'($urandom_range(0, 15));
      if (ro == 3'd4) ra = ($urandom_range(0, 20) == 0) ? 4'd15 : 4'($urandom_range(0, 2));
      cyc(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, ro, ra);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
